pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter register and fetch sequencer for the IF stage; the consumer end of the PC+1 incrementer path.
- Drives o_pc to the instruction memory and the incrementer, then receives PC+1 back on i_pc_plus1.
- Selects the next PC from PC+1, branch target or jump target, and honours hazard stalls.
- Handles run / single-step / halted execution modes for the debug unit.

Parameters:
- PC_W, 32: PC and target width.
- RESET_PC, 0: PC value after reset.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that halts fetch.
- IMEM_DEPTH, 1024: instruction memory depth in words. Used only under PC_BOUNDS_CHECK_EN.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  pulse; leaves IDLE.
- i_step_mode  in  1  sampled with i_start: 0 = continuous run, 1 = single-step.
- i_step  in  1  pulse; advances one instruction in STEP.
- i_stall  in  1  hazard unit; hold PC.
- i_branch_taken  in  1  redirect to i_branch_target.
- i_branch_target  in  PC_W  branch destination.
- i_jump  in  1  redirect to i_jump_target.
- i_jump_target  in  PC_W  jump destination.
- i_pc_plus1  in  PC_W  incrementer result for the current o_pc.
- i_instr  in  32  instruction memory read data at o_pc (combinational read).
- o_pc  out  PC_W  current PC.
- o_instr_valid  out  1  IF/ID latch enable; i_instr at o_pc is consumed this cycle.
- o_halted  out  1  fetch halted.
- o_fault  out  1  PC out of range (feature only; tied 0 otherwise).
- o_cycle_cnt  out  32  number of advance cycles.

Behaviour:
- Reset (i_rst_n=0 at a clock edge) applies from any state, including mid-run or mid-step:
  - state=IDLE, o_pc=RESET_PC.
  - o_instr_valid=0, o_halted=0, o_fault=0, o_cycle_cnt=0.
- States: IDLE, RUN, STEP, HALTED.
- IDLE:
  - i_start=1 goes to RUN if i_step_mode=0, else to STEP.
  - PC is held; o_instr_valid=0.
- "Advance" condition for a cycle:
  - RUN: advance every cycle.
  - STEP: advance only in a cycle where i_step=1. i_step held high advances every cycle it is high; the debug unit drives one-cycle pulses.
  - No advance otherwise.
- In an advance cycle, next PC by priority:
  1. i_branch_taken: i_branch_target.
  2. i_jump: i_jump_target.
  3. i_stall: hold.
  4. Otherwise: i_pc_plus1.
- Redirects override stall: the branch is resolved downstream and the fetched slot is flushed by the pipeline.
- o_instr_valid=1 in an advance cycle with no stall or redirect in effect; 0 otherwise. It is combinational from state and inputs; PC updates at the edge.
- o_cycle_cnt increments on every advance cycle, including stall cycles. It saturates at 32'hFFFF_FFFF with no wrap.
- Halt:
  - Trigger: advance cycle, i_instr==HALT_WORD, no stall, no redirect.
  - That cycle: o_instr_valid=1, so the halt word enters the pipeline.
  - PC is not updated.
  - Next state is HALTED.
- HALTED:
  - o_halted=1, o_instr_valid=0, PC frozen.
  - Only reset exits; i_start is ignored.
- A redirect coinciding with HALT_WORD at o_pc takes the redirect and does not halt.
- A stall coinciding with HALT_WORD holds and does not halt yet; the halt is retried next cycle.
- Arithmetic: no PC arithmetic inside the block; the increment comes only from i_pc_plus1. Wrap-around is therefore whatever the incrementer produces (0xFFFF_FFFF -> 0) and is accepted.

Optional Feature:
- Macro: PC_BOUNDS_CHECK_EN.
- Defined:
  - If the selected next PC >= IMEM_DEPTH in an advance cycle, the PC is not updated and o_instr_valid=0.
  - o_fault=1 and o_halted=1; state goes to HALTED. The fault is sticky until reset.
- Undefined: no check; o_fault is constant 0.

Test Plan:
- Run sequence: reset, then i_start=1 with i_step_mode=0; imem holds non-halt words at 0..4 and HALT_WORD at 5.
  - o_pc goes 0,1,2,3,4,5 on consecutive cycles.
  - o_instr_valid=1 for six cycles, then 0.
  - o_halted=1 from the cycle after PC=5; o_cycle_cnt=6.
- Stall vs branch: at PC=3, i_stall=1 for 2 cycles → PC stays 3, o_instr_valid=0, o_cycle_cnt still increments. Then i_stall=1 together with i_branch_taken=1, i_branch_target=20 → next PC=20.
- Branch beats jump: i_branch_taken=1 (target 8) and i_jump=1 (target 40) in the same cycle → PC=8.
- Step mode: i_start with i_step_mode=1, no i_step for 5 cycles → PC stays 0. Three one-cycle i_step pulses → PC 1, 2, 3, each with exactly one o_instr_valid pulse.
- Reset mid-run: at PC=7 in RUN, drive i_rst_n=0 for one edge → PC=0, state IDLE, o_cycle_cnt=0. Without i_start, PC stays 0 for 10 cycles.
- With PC_BOUNDS_CHECK_EN and IMEM_DEPTH=16: jump to 16 → o_fault=1, o_halted=1, PC unchanged. Jump to 15 instead → PC=15 with no fault.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer for the IF stage (run / single-step / halted).
// Optional PC range check enabled by defining PC_BOUNDS_CHECK_EN.
module pc_fetch_ctrl #(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [31:0]     HALT_WORD  = 32'hFFFF_FFFF,
  parameter int              IMEM_DEPTH = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_step_mode,
  input  logic            i_step,
  input  logic            i_stall,
  input  logic            i_branch_taken,
  input  logic [PC_W-1:0] i_branch_target,
  input  logic            i_jump,
  input  logic [PC_W-1:0] i_jump_target,
  input  logic [PC_W-1:0] i_pc_plus1,
  input  logic [31:0]     i_instr,
  output logic [PC_W-1:0] o_pc,
  output logic            o_instr_valid,
  output logic            o_halted,
  output logic            o_fault,
  output logic [31:0]     o_cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALTED
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [31:0]     cycle_cnt;
  logic            halted;
  logic            fault;

  logic            advance;
  logic            redirect;
  logic            halt_now;
  logic            out_of_range;
  logic [PC_W-1:0] next_pc;

`ifdef PC_BOUNDS_CHECK_EN
  localparam logic [PC_W:0] DEPTH_LIMIT = (PC_W+1)'(IMEM_DEPTH);
`endif

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    advance  = (state == S_RUN) || ((state == S_STEP) && i_step);
    redirect = i_branch_taken || i_jump;

    if (i_branch_taken)  next_pc = i_branch_target;
    else if (i_jump)     next_pc = i_jump_target;
    else if (i_stall)    next_pc = pc;
    else                 next_pc = i_pc_plus1;

    // The halt word is only honoured once it is actually consumed (no stall, no redirect).
    halt_now = advance && !redirect && !i_stall && (i_instr == HALT_WORD);

`ifdef PC_BOUNDS_CHECK_EN
    out_of_range = advance && !halt_now && ({1'b0, next_pc} >= DEPTH_LIMIT);
`else
    out_of_range = 1'b0;
`endif

    o_instr_valid = advance && !redirect && !i_stall && !out_of_range;
  end

  // NOTE: reset is synchronous, so it sits inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      cycle_cnt <= '0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) state <= i_step_mode ? S_STEP : S_RUN;
        end
        S_RUN, S_STEP: begin
          if (advance) begin
            if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
            if (halt_now) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else if (out_of_range) begin
              state  <= S_HALTED;
              halted <= 1'b1;
              fault  <= 1'b1;
            end else begin
              pc <= next_pc;
            end
          end
        end
        default: ;  // HALTED: frozen until reset
      endcase
    end
  end

  assign o_pc        = pc;
  assign o_halted    = halted;
  assign o_fault     = fault;
  assign o_cycle_cnt = cycle_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model. Honours PC_BOUNDS_CHECK_EN.
module tb_pc_fetch_ctrl;

  localparam int          PC_W  = 32;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
`ifdef PC_BOUNDS_CHECK_EN
  localparam int          DEPTH = 16;
  localparam bit          BOUNDS = 1'b1;
`else
  localparam int          DEPTH = 1024;
  localparam bit          BOUNDS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0, step_mode = 1'b0, step = 1'b0, stall = 1'b0;
  logic            branch = 1'b0, jump = 1'b0;
  logic [PC_W-1:0] branch_target = '0, jump_target = '0;
  logic [PC_W-1:0] pc_plus1;
  logic [31:0]     instr;
  logic [PC_W-1:0] pc;
  logic            instr_valid, halted, fault;
  logic [31:0]     cycle_cnt;

  logic [31:0] imem [64];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory and incrementer live in the bench.
  assign instr    = imem[pc[5:0]];
  assign pc_plus1 = pc + 1;

  pc_fetch_ctrl #(
    .PC_W(PC_W), .RESET_PC('0), .HALT_WORD(HALT), .IMEM_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_step_mode(step_mode),
    .i_step(step), .i_stall(stall), .i_branch_taken(branch),
    .i_branch_target(branch_target), .i_jump(jump), .i_jump_target(jump_target),
    .i_pc_plus1(pc_plus1), .i_instr(instr), .o_pc(pc), .o_instr_valid(instr_valid),
    .o_halted(halted), .o_fault(fault), .o_cycle_cnt(cycle_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT} mode_t;
  mode_t       m_mode = M_IDLE;
  logic [31:0] m_pc = '0;
  logic [31:0] m_cnt = '0;
  bit          m_fault = 1'b0;

  function automatic bit m_consumes();
    return (m_mode == M_RUN) || (m_mode == M_STEP && step);
  endfunction

  function automatic logic [31:0] m_target();
    if (branch)     return branch_target;
    if (jump)       return jump_target;
    if (stall)      return m_pc;
    return m_pc + 1;
  endfunction

  function automatic bit m_halts();
    return m_consumes() && !branch && !jump && !stall && imem[m_pc[5:0]] == HALT;
  endfunction

  function automatic bit m_oob();
    return BOUNDS && m_consumes() && !m_halts() && (m_target() >= 32'(DEPTH));
  endfunction

  function automatic bit m_valid();
    return m_consumes() && !branch && !jump && !stall && !m_oob();
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode  <= M_IDLE;
      m_pc    <= '0;
      m_cnt   <= '0;
      m_fault <= 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (start) m_mode <= step_mode ? M_STEP : M_RUN;
    end else if (m_consumes()) begin
      m_cnt <= (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
      if (m_halts())      m_mode <= M_HALT;
      else if (m_oob()) begin
        m_mode  <= M_HALT;
        m_fault <= 1'b1;
      end else            m_pc <= m_target();
    end
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("instr_valid", instr_valid, m_valid());
      check("halted", halted, m_mode == M_HALT);
      check("fault", fault, m_fault);
      check("cycle_cnt", cycle_cnt, m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; step_mode = 0; step = 0; stall = 0;
    branch = 0; jump = 0; branch_target = '0; jump_target = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic launch(input bit mode);
    start = 1; step_mode = mode;
    tick();
    start = 0; step_mode = 0;
  endtask

  task automatic load_linear();
    for (int i = 0; i < 64; i++) imem[i] = 32'(i) + 32'h100;
  endtask

  initial begin
    int nv;
    load_linear();
    imem[5] = HALT;
    do_reset();
    chk_en = 1'b1;

    // Reset state
    check("reset_pc", pc, 0);
    check("reset_halted", halted, 0);
    check("reset_cnt", cycle_cnt, 0);
    check("reset_valid", instr_valid, 0);

    // Run until halt word at PC 5
    launch(1'b0);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid) nv++;
      tick();
    end
    check("run_valid_count", nv, 6);
    check("run_halt_pc", pc, 5);
    check("run_halted", halted, 1);
    check("run_cnt", cycle_cnt, 6);
    start = 1; tick(); start = 0;
    check("halt_ignores_start", halted, 1);

    // Stall then stall+branch
    load_linear();
    do_reset();
    launch(1'b0);
    repeat (3) tick();
    check("at_pc3", pc, 3);
    stall = 1;
    #1 check("stall_valid", instr_valid, 0);
    repeat (2) tick();
    check("stall_hold_pc", pc, 3);
    check("stall_cnt", cycle_cnt, 5);
    branch = 1; branch_target = 20;
    tick();
    clear_inputs();
    check("branch_over_stall", pc, 20);
    check("branch_cnt", cycle_cnt, 6);

    // Branch beats jump
    branch = 1; branch_target = 8; jump = 1; jump_target = 40;
    tick();
    clear_inputs();
    check("branch_beats_jump", pc, 8);

    // Stall with halt word retries next cycle
    imem[9] = HALT;
    tick();
    stall = 1; tick(); stall = 0;
    check("stall_on_halt_pc", pc, 9);
    check("stall_on_halt_not_halted", halted, 0);
    tick();
    check("halt_after_stall", halted, 1);

    // Redirect with halt word at PC takes the redirect
    load_linear();
    imem[0] = HALT;
    do_reset();
    launch(1'b0);
    jump = 1; jump_target = 12; tick(); clear_inputs();
    check("redirect_over_halt_pc", pc, 12);
    check("redirect_over_halt_halted", halted, 0);

    // Single-step mode
    load_linear();
    do_reset();
    launch(1'b1);
    repeat (5) tick();
    check("step_idle_pc", pc, 0);
    for (int i = 1; i <= 3; i++) begin
      step = 1;
      #1 check("step_valid_pulse", instr_valid, 1);
      tick();
      step = 0;
      #1 check("step_valid_low", instr_valid, 0);
      tick();
      check("step_pc", pc, 32'(i));
    end
    check("step_cnt", cycle_cnt, 3);

    // Reset mid-run
    do_reset();
    launch(1'b0);
    repeat (7) tick();
    check("midrun_pc7", pc, 7);
    do_reset();
    check("midrun_reset_pc", pc, 0);
    check("midrun_reset_cnt", cycle_cnt, 0);
    repeat (10) tick();
    check("idle_hold_pc", pc, 0);

`ifdef PC_BOUNDS_CHECK_EN
    do_reset();
    launch(1'b0);
    jump = 1; jump_target = 16; tick(); clear_inputs();
    check("oob_fault", fault, 1);
    check("oob_halted", halted, 1);
    check("oob_pc", pc, 0);
    do_reset();
    launch(1'b0);
    jump = 1; jump_target = 15; tick(); clear_inputs();
    check("inb_pc", pc, 15);
    check("inb_fault", fault, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 64; i++)
      imem[i] = ($urandom_range(0, 19) == 0) ? HALT : $urandom;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n         = ($urandom_range(0, 47) != 0);
      start         = ($urandom_range(0, 5) == 0);
      step_mode     = $urandom_range(0, 1);
      step          = ($urandom_range(0, 2) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch        = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 7) == 0);
      branch_target = $urandom_range(0, BOUNDS ? 20 : 63);
      jump_target   = $urandom_range(0, BOUNDS ? 20 : 63);
      tick();
    end
    clear_inputs();
    rst_n = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
